// File: rtl/mem_axi_bridge.sv
// Data-side AXI4-Lite master for the pipeline memory port: turns one captured
// load/store request into AXI transactions and stalls the core until done.
`timescale 1ns/1ps
module mem_axi_bridge #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int STRB_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd_en_i,
  input  logic              mem_wr_en_i,
  input  logic [ADDR_W-1:0] addr_mem_rd_i,
  input  logic [ADDR_W-1:0] addr_mem_wr_i,
  input  logic [DATA_W-1:0] data_mem_wr_i,
  input  logic [STRB_W-1:0] strb_mem_wr_i,
  output logic [DATA_W-1:0] data_mem_o,
  output logic              stall_mem_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [2:0]        awprot_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [2:0]        arprot_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_pend_q, rd_pend_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              err_q, err_d;
  logic              aw_fin, w_fin;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      rd_pend_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      rd_pend_q <= rd_pend_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  // A channel counts as finished once its handshake has happened, either in an
  // earlier cycle (done flag) or right now.
  assign aw_fin = aw_done_q | awready_i;
  assign w_fin  = w_done_q | wready_i;

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    rd_pend_d   = rd_pend_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    err_d       = err_q;
    stall_mem_o = 1'b1;
    bus_err_o   = 1'b0;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    bready_o    = 1'b0;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;

    case (state_q)
      IDLE: begin
        stall_mem_o = mem_rd_en_i | mem_wr_en_i;
        if (mem_wr_en_i) begin
          awaddr_d  = addr_mem_wr_i;
          wdata_d   = data_mem_wr_i;
          wstrb_d   = strb_mem_wr_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rd_pend_d = mem_rd_en_i;
          if (mem_rd_en_i) araddr_d = addr_mem_rd_i;
          state_d = WR;
        end else if (mem_rd_en_i) begin
          araddr_d  = addr_mem_rd_i;
          rd_pend_d = 1'b0;
          state_d   = RD_ADDR;
        end
      end
      WR: begin
        awvalid_o = ~aw_done_q;
        wvalid_o  = ~w_done_q;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          if (bresp_i != 2'b00) err_d = 1'b1;
          state_d = rd_pend_q ? RD_ADDR : DONE;
        end
      end
      RD_ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          if (rresp_i != 2'b00) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = rdata_i;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        // Request inputs still show the finished access; they are not sampled here.
        stall_mem_o = 1'b0;
        bus_err_o   = err_q;
        err_d       = 1'b0;
        rd_pend_d   = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_mem_o = rdata_q;
  assign awaddr_o   = awaddr_q;
  assign araddr_o   = araddr_q;
  assign wdata_o    = wdata_q;
  assign wstrb_o    = wstrb_q;
  assign awprot_o   = 3'b000;
  assign arprot_o   = 3'b000;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Randomized scoreboard bench for mem_axi_bridge: a core driver plus an AXI4-Lite
// slave with per-transaction latencies, checked against a word-memory model.
`timescale 1ns/1ps
module tb_mem_axi_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd_en_i = 1'b0, mem_wr_en_i = 1'b0;
  logic [63:0] addr_mem_rd_i = '0, addr_mem_wr_i = '0, data_mem_wr_i = '0;
  logic [7:0]  strb_mem_wr_i = '0;
  logic [63:0] data_mem_o;
  logic        stall_mem_o, bus_err_o;
  logic [63:0] awaddr_o, araddr_o, wdata_o;
  logic [2:0]  awprot_o, arprot_o;
  logic [7:0]  wstrb_o;
  logic        awvalid_o, awready_i, wvalid_o, wready_i;
  logic [1:0]  bresp_i, rresp_i;
  logic        bvalid_i, bready_o, arvalid_o, arready_i;
  logic [63:0] rdata_i;
  logic        rvalid_i, rready_o;

  always #5 clk = ~clk;

  mem_axi_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_en_i(mem_rd_en_i), .mem_wr_en_i(mem_wr_en_i),
    .addr_mem_rd_i(addr_mem_rd_i), .addr_mem_wr_i(addr_mem_wr_i),
    .data_mem_wr_i(data_mem_wr_i), .strb_mem_wr_i(strb_mem_wr_i),
    .data_mem_o(data_mem_o), .stall_mem_o(stall_mem_o), .bus_err_o(bus_err_o),
    .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  // Addresses with top nibble E form an unmapped hole answered with SLVERR.
  function automatic logic is_err(input logic [63:0] a);
    return a[63:60] == 4'hE;
  endfunction

  function automatic logic [63:0] init_word(input int i);
    if (i == 2) return 64'hDEAD_BEEF_0123_4567;
    return {32'hC0DE_0000 + i, 32'h1234_5678 ^ i};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- AXI4-Lite slave with configurable latencies ----------------
  int da_cfg = 0, dw_cfg = 0, db_cfg = 0, dar_cfg = 0, dr_cfg = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_have, w_have, b_pend, r_pend;
  logic [63:0] s_awaddr, s_wdata, s_rdata;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic [63:0] slave_mem [0:63];

  assign awready_i = awvalid_o && (aw_cnt == da_cfg);
  assign wready_i  = wvalid_o && (w_cnt == dw_cfg);
  assign arready_i = arvalid_o && (ar_cnt == dar_cfg);
  assign bvalid_i  = b_pend && (b_cnt == db_cfg);
  assign rvalid_i  = r_pend && (r_cnt == dr_cfg);
  assign bresp_i   = s_bresp;
  assign rresp_i   = s_rresp;
  assign rdata_i   = s_rdata;

  wire         aw_hs = awvalid_o && awready_i;
  wire         w_hs  = wvalid_o && wready_i;
  wire [63:0]  sl_wa = aw_hs ? awaddr_o : s_awaddr;
  wire [63:0]  sl_wd = w_hs ? wdata_o : s_wdata;
  wire [7:0]   sl_ws = w_hs ? wstrb_o : s_wstrb;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_have <= 1'b0; w_have <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
      s_bresp <= 2'b00; s_rresp <= 2'b00;
      for (int i = 0; i < 64; i++) slave_mem[i] <= init_word(i);
    end else begin
      if (awvalid_o) aw_cnt <= awready_i ? 0 : aw_cnt + 1;
      if (wvalid_o)  w_cnt  <= wready_i ? 0 : w_cnt + 1;
      if (arvalid_o) ar_cnt <= arready_i ? 0 : ar_cnt + 1;
      if (aw_hs) begin s_awaddr <= awaddr_o; aw_have <= 1'b1; end
      if (w_hs)  begin s_wdata <= wdata_o; s_wstrb <= wstrb_o; w_have <= 1'b1; end
      if (!b_pend && (aw_have || aw_hs) && (w_have || w_hs)) begin
        b_pend <= 1'b1;
        b_cnt  <= 0;
        if (!is_err(sl_wa)) slave_mem[sl_wa[8:3]] <= merge(slave_mem[sl_wa[8:3]], sl_wd, sl_ws);
        s_bresp <= is_err(sl_wa) ? 2'b10 : 2'b00;
      end else if (b_pend) begin
        if (bvalid_i && bready_o) begin
          b_pend <= 1'b0; aw_have <= 1'b0; w_have <= 1'b0;
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
      if (arvalid_o && arready_i) begin
        r_pend  <= 1'b1;
        r_cnt   <= 0;
        s_rresp <= is_err(araddr_o) ? 2'b10 : 2'b00;
        s_rdata <= is_err(araddr_o) ? 64'hBAD0_BAD0_BAD0_BAD0 : slave_mem[araddr_o[8:3]];
      end else if (r_pend) begin
        if (rvalid_i && rready_o) r_pend <= 1'b0;
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- reference model and scoreboard queues ----------------
  typedef struct packed { logic [63:0] data; logic err; } done_t;
  logic [63:0] aw_q[$];
  logic [71:0] w_q[$];
  logic [63:0] ar_q[$];
  done_t       done_q[$];
  int          b_q = 0;
  logic [63:0] model_mem [0:63];
  logic [63:0] last_read = '0;

  task automatic model_init();
    for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
    last_read = '0;
  endtask

  task automatic run_txn(input bit wr, input bit rd, input logic [63:0] wa, input logic [63:0] wd,
                         input logic [7:0] ws, input logic [63:0] ra,
                         input int da, input int dw, input int db, input int dar, input int dr);
    logic e;
    int   exp_stall, n, wmax;
    bit   done;
    e = 1'b0;
    if (wr) begin
      aw_q.push_back(wa);
      w_q.push_back({wd, ws});
      b_q++;
      if (is_err(wa)) e = 1'b1;
      else model_mem[wa[8:3]] = merge(model_mem[wa[8:3]], wd, ws);
    end
    if (rd) begin
      ar_q.push_back(ra);
      if (is_err(ra)) begin e = 1'b1; last_read = '0; end
      else last_read = model_mem[ra[8:3]];
    end
    done_q.push_back('{data: last_read, err: e});
    wmax = (da > dw) ? da : dw;
    exp_stall = 1 + (wr ? (wmax + 1) + (db + 1) : 0) + (rd ? (dar + 1) + (dr + 1) : 0);
    da_cfg = da; dw_cfg = dw; db_cfg = db; dar_cfg = dar; dr_cfg = dr;
    mem_wr_en_i = wr; mem_rd_en_i = rd;
    addr_mem_wr_i = wa; data_mem_wr_i = wd; strb_mem_wr_i = ws; addr_mem_rd_i = ra;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (stall_mem_o) n++;
      else begin done = 1'b1; break; end
    end
    chk("txn_completes", done, 1'b1);
    chk("stall_cycles", n, exp_stall);
    @(posedge clk); #1;
    mem_wr_en_i = 1'b0; mem_rd_en_i = 1'b0;
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [63:0] a;
    a = 64'h8000_0000 + {$urandom_range(0, 63), 3'b000} + $urandom_range(0, 7);
    if ($urandom_range(0, 9) == 0) a[63:60] = 4'hE;
    return a;
  endfunction

  // ---------------- monitor ----------------
  logic        aw_wait_prev = 1'b0, w_wait_prev = 1'b0, ar_wait_prev = 1'b0;
  logic [63:0] aw_prev, ar_prev;
  logic [71:0] w_prev;

  initial begin
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_wait_prev = 1'b0; w_wait_prev = 1'b0; ar_wait_prev = 1'b0;
        continue;
      end
      if (aw_wait_prev) chk("aw_hold", {awvalid_o, awaddr_o}, {1'b1, aw_prev});
      if (w_wait_prev)  chk("w_hold", {wvalid_o, wdata_o, wstrb_o}, {1'b1, w_prev});
      if (ar_wait_prev) chk("ar_hold", {arvalid_o, araddr_o}, {1'b1, ar_prev});
      if (awvalid_o && awready_i) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
        else chk("aw_addr", awaddr_o, aw_q.pop_front());
      end
      if (wvalid_o && wready_i) begin
        if (w_q.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
        else chk("w_data_strb", {wdata_o, wstrb_o}, w_q.pop_front());
      end
      if (bvalid_i && bready_o) begin
        chk("b_expected", b_q > 0, 1'b1);
        if (b_q > 0) b_q--;
      end
      if (arvalid_o && arready_i) begin
        chk("ar_after_b", b_q, 0);
        if (ar_q.size() == 0) chk("ar_unexpected", 1'b1, 1'b0);
        else chk("ar_addr", araddr_o, ar_q.pop_front());
      end
      if ((mem_rd_en_i || mem_wr_en_i) && !stall_mem_o) begin
        if (done_q.size() == 0) chk("done_unexpected", 1'b1, 1'b0);
        else begin
          d = done_q.pop_front();
          chk("load_data", data_mem_o, d.data);
          chk("bus_err_done", bus_err_o, d.err);
        end
      end else begin
        chk("bus_err_quiet", bus_err_o, 1'b0);
      end
      aw_wait_prev = awvalid_o && !awready_i; aw_prev = awaddr_o;
      w_wait_prev  = wvalid_o && !wready_i;   w_prev  = {wdata_o, wstrb_o};
      ar_wait_prev = arvalid_o && !arready_i; ar_prev = araddr_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    bit reached;
    int kind;
    model_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 5'b0);
    chk("rst_regs", {data_mem_o, awaddr_o}, 128'h0);
    chk("rst_regs2", {araddr_o, wdata_o, wstrb_o}, 136'h0);
    chk("rst_err_stall", {bus_err_o, stall_mem_o}, 2'b00);
    chk("prot_zero", {awprot_o, arprot_o}, 6'b0);
    mem_rd_en_i = 1'b1; #1;
    chk("rst_idle_stall_rule", stall_mem_o, 1'b1);
    mem_rd_en_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_txn(0, 1, '0, '0, '0, 64'h8000_0010, 0, 0, 0, 0, 0);
    run_txn(1, 0, 64'h8000_0003, 64'h0000_0000_1100_0000, 8'h08, '0, 0, 3, 0, 0, 0);
    run_txn(1, 0, 64'h8000_0020, 64'h0102_0304_0506_0708, 8'hFF, '0, 0, 0, 0, 0, 0);
    run_txn(1, 0, 64'h8000_0028, 64'hA5A5_5A5A_F0F0_0F0F, 8'h3C, '0, 2, 0, 1, 0, 0);
    run_txn(0, 1, '0, '0, '0, 64'hE000_0000_8000_0020, 0, 0, 0, 0, 0);
    run_txn(1, 1, 64'h8000_0018, 64'h7777_8888_9999_AAAA, 8'hF0, 64'h8000_0018, 1, 1, 1, 1, 1);
    run_txn(0, 1, '0, '0, '0, 64'h8000_0000, 0, 0, 0, 2, 2);

    // Reset while the read data phase is waiting on the slave.
    ar_q.push_back(64'h8000_0008);
    dar_cfg = 0; dr_cfg = 30;
    addr_mem_rd_i = 64'h8000_0008; mem_rd_en_i = 1'b1;
    reached = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rready_o) begin reached = 1'b1; break; end
    end
    chk("reach_rd_data", reached, 1'b1);
    rst_n = 1'b0; mem_rd_en_i = 1'b0;
    @(negedge clk);
    chk("midrst_valids", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 5'b0);
    chk("midrst_data", data_mem_o, 64'h0);
    chk("midrst_stall", stall_mem_o, 1'b0);
    aw_q.delete(); w_q.delete(); ar_q.delete(); done_q.delete(); b_q = 0;
    model_init();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 2);
      run_txn(kind != 0, kind != 1, rnd_addr(), {$urandom, $urandom}, 8'($urandom_range(1, 255)),
              rnd_addr(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(negedge clk);
    chk("queues_drained", aw_q.size() + w_q.size() + ar_q.size() + done_q.size() + b_q, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
